// File: rtl/demux_1_4_reg_if.sv
// Bus bundle for demux_1_4_reg: upstream valid/ready word plus four held output channels.
interface demux_1_4_reg_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_VALID;
  logic             IN_READY;
  logic [1:0]       S;
  logic [WIDTH-1:0] OUT_DATA0;
  logic [WIDTH-1:0] OUT_DATA1;
  logic [WIDTH-1:0] OUT_DATA2;
  logic [WIDTH-1:0] OUT_DATA3;
  logic [3:0]       OUT_VALID;
  logic [3:0]       OUT_READY;
  logic [1:0]       RR_PTR;

  // Producer and consumer side, as seen by the environment.
  modport master (
    output IN_DATA, IN_VALID, S, OUT_READY,
    input  IN_READY, OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3, OUT_VALID, RR_PTR
  );

  // Demux side.
  modport slave (
    input  IN_DATA, IN_VALID, S, OUT_READY,
    output IN_READY, OUT_DATA0, OUT_DATA1, OUT_DATA2, OUT_DATA3, OUT_VALID, RR_PTR
  );
endinterface

// File: rtl/demux_1_4_reg.sv
// Registered 1-to-4 demultiplexer: steers each accepted word into one of four
// one-entry holding registers, chosen by S or by an internal round-robin pointer.
module demux_1_4_reg #(
  parameter int unsigned WIDTH   = 8,
  parameter bit          RR_MODE = 1'b0
) (
  input  logic           CLK,
  input  logic           RST,
  demux_1_4_reg_if.slave bus
);
  localparam int unsigned N_CH = 4;

  logic [WIDTH-1:0] r_data [N_CH];
  logic [N_CH-1:0]  r_valid;
  logic [1:0]       r_ptr;

  logic [1:0]       w_dest;
  logic             w_in_ready;
  logic             w_accept;
  logic [N_CH-1:0]  w_load;
  logic [N_CH-1:0]  w_drain;

  // A channel can take a word when empty or when it is being drained this cycle.
  always_comb begin
    w_dest     = RR_MODE ? r_ptr : bus.S;
    w_in_ready = ~RST & (~r_valid[w_dest] | bus.OUT_READY[w_dest]);
    w_accept   = bus.IN_VALID & w_in_ready;
    w_drain    = r_valid & bus.OUT_READY;
    w_load     = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_load[k] = w_accept & (w_dest == 2'(k));
    end
  end

  // Load wins over drain so a back-to-back word keeps the channel full.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= '0;
      r_ptr   <= '0;
      for (int k = 0; k < N_CH; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (w_load[k]) begin
          r_data[k]  <= bus.IN_DATA;
          r_valid[k] <= 1'b1;
        end else if (w_drain[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
      if (RR_MODE && w_accept) begin
        r_ptr <= r_ptr + 2'd1;
      end
    end
  end

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_DATA0 = r_data[0];
  assign bus.OUT_DATA1 = r_data[1];
  assign bus.OUT_DATA2 = r_data[2];
  assign bus.OUT_DATA3 = r_data[3];
  assign bus.OUT_VALID = r_valid;
  assign bus.RR_PTR    = r_ptr;
endmodule

// File: tb/tb_demux_1_4_reg.sv
// Scoreboard bench for demux_1_4_reg: one instance in select mode (a), one in round-robin mode (b).
module tb_demux_1_4_reg;
  logic CLK;
  logic RST;

  int n_cmp;
  int n_err;

  // Expected words per destination; index = mode*4 + channel.
  logic [7:0] exp_q [8][$];

  demux_1_4_reg_if #(.WIDTH(8)) a ();
  demux_1_4_reg_if #(.WIDTH(8)) b ();

  demux_1_4_reg #(.WIDTH(8), .RR_MODE(1'b0)) dut_a (.CLK(CLK), .RST(RST), .bus(a.slave));
  demux_1_4_reg #(.WIDTH(8), .RR_MODE(1'b1)) dut_b (.CLK(CLK), .RST(RST), .bus(b.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_ready(input bit rr);
    return rr ? b.IN_READY : a.IN_READY;
  endfunction

  function automatic logic [3:0] get_ov(input bit rr);
    return rr ? b.OUT_VALID : a.OUT_VALID;
  endfunction

  function automatic logic [3:0] get_or(input bit rr);
    return rr ? b.OUT_READY : a.OUT_READY;
  endfunction

  function automatic logic [7:0] get_od(input bit rr, input int k);
    case (k)
      0:       return rr ? b.OUT_DATA0 : a.OUT_DATA0;
      1:       return rr ? b.OUT_DATA1 : a.OUT_DATA1;
      2:       return rr ? b.OUT_DATA2 : a.OUT_DATA2;
      default: return rr ? b.OUT_DATA3 : a.OUT_DATA3;
    endcase
  endfunction

  task automatic drive(input bit rr, input logic v, input logic [7:0] d, input logic [1:0] s);
    if (rr) begin
      b.IN_VALID = v; b.IN_DATA = d; b.S = s;
    end else begin
      a.IN_VALID = v; a.IN_DATA = d; a.S = s;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one word, wait (bounded) for IN_READY, record where it must come out.
  task automatic send(input bit rr, input logic [7:0] d, input logic [1:0] s,
                      input int ch, input bit imm);
    int waited;
    bit ok;
    logic [3:0] ov;
    waited = 0;
    ok = 1'b0;
    drive(rr, 1'b1, d, s);
    while (!ok && waited < 20) begin
      @(negedge CLK);
      if (get_ready(rr)) ok = 1'b1;
      else begin
        waited++;
        tick();
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: word 0x%0h never accepted, required acceptance", d);
      drive(rr, 1'b0, d, s);
      return;
    end
    exp_q[int'(rr) * 4 + ch].push_back(d);
    if (imm) check($sformatf("no_stall_%0h", d), 32'(waited), 32'd0);
    tick();
    drive(rr, 1'b0, d, s);
    ov = get_ov(rr);
    check($sformatf("valid_after_accept_%0h", d), 32'(ov[ch]), 32'd1);
  endtask

  // Monitor: every delivery (valid & ready) must match the head of that channel's queue.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) begin
          logic [3:0] ov;
          logic [3:0] orr;
          ov  = get_ov(d[0]);
          orr = get_or(d[0]);
          if (ov[k] && orr[k]) begin
            if (exp_q[d * 4 + k].size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_delivery dut%0d ch%0d: got 0x%0h required none",
                       d, k, get_od(d[0], k));
            end else begin
              check($sformatf("deliver_dut%0d_ch%0d", d, k), 32'(get_od(d[0], k)),
                    32'(exp_q[d * 4 + k].pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] ov;
    n_cmp = 0;
    n_err = 0;
    RST = 1'b1;
    a.OUT_READY = 4'h0;
    b.OUT_READY = 4'h0;
    drive(1'b0, 1'b1, 8'hEE, 2'd1);
    drive(1'b1, 1'b1, 8'hEE, 2'd1);

    // Reset with IN_VALID high for two cycles.
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge CLK);
      check("rst_valid_a", 32'(a.OUT_VALID), 32'h0);
      check("rst_valid_b", 32'(b.OUT_VALID), 32'h0);
      check("rst_ready_a", 32'(a.IN_READY), 32'h0);
      check("rst_ready_b", 32'(b.IN_READY), 32'h0);
      check("rst_ptr_b", 32'(b.RR_PTR), 32'h0);
    end
    for (int k = 0; k < 4; k++) check($sformatf("rst_data_ch%0d", k), 32'(get_od(1'b1, k)), 32'h0);
    tick();
    RST = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 2'd0);
    drive(1'b1, 1'b0, 8'h00, 2'd0);
    @(negedge CLK);
    check("post_rst_ready_a", 32'(a.IN_READY), 32'h1);
    check("post_rst_ready_b", 32'(b.IN_READY), 32'h1);
    check("post_rst_nothing_accepted", 32'(a.OUT_VALID), 32'h0);
    check("ptr_a_zero", 32'(a.RR_PTR), 32'h0);
    tick();

    // Select mode, one word per channel on consecutive cycles.
    a.OUT_READY = 4'hF;
    send(1'b0, 8'hA0, 2'd0, 0, 1'b1);
    send(1'b0, 8'hA1, 2'd1, 1, 1'b1);
    send(1'b0, 8'hA2, 2'd2, 2, 1'b1);
    send(1'b0, 8'hA3, 2'd3, 3, 1'b1);
    tick();
    check("select_pulse_done", 32'(a.OUT_VALID), 32'h0);

    // Backpressure on channel 2, then redirect the waiting word to channel 0.
    a.OUT_READY = 4'b1011;
    send(1'b0, 8'h11, 2'd2, 2, 1'b1);
    drive(1'b0, 1'b1, 8'h22, 2'd2);
    @(negedge CLK);
    check("bp_ready_s2_c0", 32'(a.IN_READY), 32'h0);
    tick();
    @(negedge CLK);
    check("bp_ready_s2_c1", 32'(a.IN_READY), 32'h0);
    check("bp_hold_data2", 32'(a.OUT_DATA2), 32'h11);
    check("bp_hold_valid", 32'(a.OUT_VALID), 32'b0100);
    tick();
    drive(1'b0, 1'b1, 8'h22, 2'd0);
    @(negedge CLK);
    check("bp_ready_s0", 32'(a.IN_READY), 32'h1);
    if (a.IN_READY) exp_q[0].push_back(8'h22);
    tick();
    drive(1'b0, 1'b0, 8'h22, 2'd0);
    check("bp_redirect_valid", 32'(a.OUT_VALID), 32'b0101);
    a.OUT_READY = 4'hF;
    tick();
    tick();

    // Simultaneous drain and load on channel 1.
    a.OUT_READY = 4'b1101;
    send(1'b0, 8'h55, 2'd1, 1, 1'b1);
    a.OUT_READY = 4'hF;
    send(1'b0, 8'h66, 2'd1, 1, 1'b1);
    check("drain_load_data1", 32'(a.OUT_DATA1), 32'h66);
    tick();
    tick();
    for (int k = 0; k < 4; k++) check($sformatf("a_queue_empty_ch%0d", k), 32'(exp_q[k].size()), 32'h0);

    // Round-robin: consumer 1 stalled, pointer wraps, sixth word waits on channel 1.
    b.OUT_READY = 4'b1101;
    send(1'b1, 8'h00, 2'd3, 0, 1'b1);
    send(1'b1, 8'h01, 2'd3, 1, 1'b1);
    send(1'b1, 8'h02, 2'd0, 2, 1'b1);
    send(1'b1, 8'h03, 2'd1, 3, 1'b1);
    check("rr_wrap_ptr", 32'(b.RR_PTR), 32'h0);
    send(1'b1, 8'h04, 2'd2, 0, 1'b1);
    check("rr_ptr_after_4", 32'(b.RR_PTR), 32'h1);
    drive(1'b1, 1'b1, 8'h05, 2'd2);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("rr_stall_ready", 32'(b.IN_READY), 32'h0);
      check("rr_stall_ptr", 32'(b.RR_PTR), 32'h1);
      tick();
    end
    b.OUT_READY = 4'hF;
    send(1'b1, 8'h05, 2'd2, 1, 1'b1);
    check("rr_ptr_after_5", 32'(b.RR_PTR), 32'h2);

    // Reset mid-stream with channels 0 and 3 full and pointer at 2.
    b.OUT_READY = 4'b0110;
    send(1'b1, 8'h30, 2'd0, 2, 1'b1);
    send(1'b1, 8'h31, 2'd0, 3, 1'b1);
    send(1'b1, 8'h32, 2'd0, 0, 1'b1);
    send(1'b1, 8'h33, 2'd0, 1, 1'b1);
    @(negedge CLK);
    tick();
    check("pre_rst_valid", 32'(b.OUT_VALID), 32'b1001);
    check("pre_rst_ptr", 32'(b.RR_PTR), 32'h2);
    RST = 1'b1;
    drive(1'b1, 1'b1, 8'h77, 2'd0);
    @(negedge CLK);
    check("mid_rst_ready", 32'(b.IN_READY), 32'h0);
    tick();
    RST = 1'b0;
    drive(1'b1, 1'b0, 8'h77, 2'd0);
    for (int i = 0; i < 8; i++) exp_q[i].delete();
    check("mid_rst_valid_b", 32'(b.OUT_VALID), 32'h0);
    check("mid_rst_ptr_b", 32'(b.RR_PTR), 32'h0);
    check("mid_rst_valid_a", 32'(a.OUT_VALID), 32'h0);
    b.OUT_READY = 4'hF;
    send(1'b1, 8'h88, 2'd3, 0, 1'b1);
    ov = b.OUT_VALID;
    check("post_rst_dest_ch0", 32'(ov), 32'b0001);
    tick();
    tick();
    tick();
    for (int i = 0; i < 8; i++) check($sformatf("final_queue_empty_%0d", i), 32'(exp_q[i].size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
